// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory behind a req/ready/resp_valid handshake.
// Byte/half/word accesses with load extension, optional wait states and fault checks.
module data_memory_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BA_W  = ADDR_W + 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]      r_cnt;
    logic            r_we;
    logic            r_sx;
    logic            r_fault;
    logic [1:0]      r_size;
    logic [BA_W-1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;

    logic [31:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_bad_size;
    logic              w_misalign;
    logic              w_range;
    logic              w_bad;
    logic              w_commit;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wlanes;
    logic [31:0]       w_word;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;

    assign w_accept   = req && ready;
    assign w_bad_size = (size == 2'b11);
    assign w_misalign = ((size == SZ_HALF) && addr[0])
                     || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign w_range    = |addr[31:BA_W];
    assign w_bad      = w_bad_size || w_misalign || w_range;

    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[BA_W-1:2];
    assign w_lane   = r_addr[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_bad ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ready      = rst_n && (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        fault      = (r_state == S_RESP) && r_fault;
        rdata      = r_rdata;
    end

    // Store lane enables and replicated write data
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_size)
            SZ_BYTE: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = r_wdata;
            end
        endcase
    end

    // Load lane select, right-justify and extend
    always_comb begin
        w_word  = r_mem[w_idx];
        w_shift = w_word >> {w_lane, 3'b000};
        w_load  = w_word;
        case (r_size)
            SZ_BYTE: begin
                w_load = {{24{r_sx & w_shift[7]}}, w_shift[7:0]};
            end
            SZ_HALF: begin
                w_load = {{16{r_sx & w_shift[15]}}, w_shift[15:0]};
            end
            default: begin
                w_load = w_word;
            end
        endcase
    end

    // Request capture, wait counter and response data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_sx    <= 1'b0;
            r_fault <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we    <= we;
                r_sx    <= sign_ext;
                r_size  <= size;
                r_addr  <= addr[BA_W-1:0];
                r_wdata <= wdata;
                r_fault <= w_bad;
                r_cnt   <= 4'(WAIT_CYCLES);
                if (w_bad) begin
                    r_rdata <= 32'd0;
                end
            end else if (r_state == S_WAIT) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_rdata <= r_we ? 32'd0 : w_load;
                end
            end
        end
    end

    // Storage array is never cleared; writes only land on a commit outside reset
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && r_we) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_wlanes[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: one instance with no wait states,
// one with three, checking response data, fault, latency and busy time.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        req        [2];
    logic        we         [2];
    logic [31:0] addr       [2];
    logic [1:0]  size       [2];
    logic        sx         [2];
    logic [31:0] wdata      [2];
    logic        ready      [2];
    logic        resp_valid [2];
    logic [31:0] rdata      [2];
    logic        fault      [2];

    int n_vec = 0;
    int n_err = 0;

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    data_memory_ctrl #(.ADDR_W(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]),
        .addr(addr[0]), .size(size[0]), .sign_ext(sx[0]),
        .wdata(wdata[0]), .ready(ready[0]), .resp_valid(resp_valid[0]),
        .rdata(rdata[0]), .fault(fault[0])
    );

    data_memory_ctrl #(.ADDR_W(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]),
        .addr(addr[1]), .size(size[1]), .sign_ext(sx[1]),
        .wdata(wdata[1]), .ready(ready[1]), .resp_valid(resp_valid[1]),
        .rdata(rdata[1]), .fault(fault[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request on instance d, queue its expected response and
    // track latency and busy time until ready returns.
    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic s,
                          input logic [31:0] wd, input logic ef,
                          input logic [31:0] er, input bit poke);
        int wc;
        int lat;
        int busy;
        wc   = (d == 0) ? 0 : 3;
        lat  = -1;
        busy = 0;
        for (int n = 0; n < 50 && !ready[d]; n++) @(negedge clk);
        check($sformatf("ready_before_req%0d", d), 32'(ready[d]), 32'd1);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        size[d]  = sz;
        sx[d]    = s;
        wdata[d] = wd;
        if (d == 0) q0.push_back({ef, er});
        else        q1.push_back({ef, er});
        @(negedge clk);
        req[d] = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (resp_valid[d] && lat < 0) lat = n;
            if (ready[d]) break;
            busy++;
            req[d] = poke && (n % 2 == 0);
            @(negedge clk);
        end
        req[d] = 1'b0;
        check($sformatf("latency%0d@%h", d, a), 32'(lat),
              ef ? 32'd0 : 32'(1 + wc));
        check($sformatf("busy%0d@%h", d, a), 32'(busy),
              ef ? 32'd1 : 32'(2 + wc));
    endtask

    always @(negedge clk) begin
        if (resp_valid[0]) begin
            logic [32:0] e;
            check("resp_pending0", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("fault0", 32'(fault[0]), 32'(e[32]));
                check("rdata0", rdata[0], e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid[1]) begin
            logic [32:0] e;
            check("resp_pending3", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("fault3", 32'(fault[1]), 32'(e[32]));
                check("rdata3", rdata[1], e[31:0]);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = 32'd0; size[d] = 2'b00; sx[d] = 1'b0;
            wdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(ready[0]),      32'd0);
        check("rst_resp",   32'(resp_valid[0]), 32'd0);
        check("rst_fault",  32'(fault[0]),      32'd0);
        check("rst_rdata",  rdata[0],           32'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("rel_ready0", 32'(ready[0]), 32'd1);
        check("rel_ready3", 32'(ready[1]), 32'd1);

        // Word store/load, then byte store and extension variants
        do_req(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0, 0);
        do_req(0, 0, 32'h10, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 0);
        do_req(0, 1, 32'h13, 2'b00, 0, 32'h123456A5, 0, 32'h0, 0);
        do_req(0, 0, 32'h13, 2'b00, 1, 32'h0, 0, 32'hFFFFFFA5, 0);
        do_req(0, 0, 32'h13, 2'b00, 0, 32'h0, 0, 32'h000000A5, 0);
        do_req(0, 0, 32'h10, 2'b10, 1, 32'h0, 0, 32'hA5ADBEEF, 0);
        do_req(0, 0, 32'h12, 2'b01, 1, 32'h0, 0, 32'hFFFFA5AD, 0);
        do_req(0, 0, 32'h12, 2'b01, 0, 32'h0, 0, 32'h0000A5AD, 0);
        do_req(0, 0, 32'h10, 2'b00, 1, 32'h0, 0, 32'hFFFFFFEF, 0);
        do_req(0, 0, 32'h11, 2'b00, 0, 32'h0, 0, 32'h000000BE, 0);
        do_req(0, 1, 32'h12, 2'b01, 0, 32'hFFFF7F01, 0, 32'h0, 0);
        do_req(0, 0, 32'h12, 2'b01, 1, 32'h0, 0, 32'h00007F01, 0);

        // Faulting requests leave memory untouched
        do_req(0, 1, 32'h11, 2'b01, 0, 32'hFFFFFFFF, 1, 32'h0, 0);
        do_req(0, 1, 32'h10, 2'b11, 0, 32'h11111111, 1, 32'h0, 0);
        do_req(0, 1, 32'h12, 2'b10, 0, 32'h22222222, 1, 32'h0, 0);
        do_req(0, 0, 32'h10, 2'b10, 0, 32'h0, 0, 32'h7F01BEEF, 0);

        // Address range edge
        do_req(0, 0, 32'h0004_0000, 2'b10, 0, 32'h0, 1, 32'h0, 0);
        do_req(0, 1, 32'h8000_0010, 2'b10, 0, 32'h33333333, 1, 32'h0, 0);
        do_req(0, 1, 32'h0003_FFFC, 2'b10, 0, 32'h55AA1234, 0, 32'h0, 0);
        do_req(0, 0, 32'h0003_FFFC, 2'b10, 0, 32'h0, 0, 32'h55AA1234, 0);
        do_req(0, 0, 32'h10, 2'b10, 0, 32'h0, 0, 32'h7F01BEEF, 0);

        // Wait states with req pulses while busy
        do_req(1, 1, 32'h20, 2'b10, 0, 32'hCAFEF00D, 0, 32'h0, 1);
        do_req(1, 0, 32'h20, 2'b10, 0, 32'h0, 0, 32'hCAFEF00D, 1);
        do_req(1, 0, 32'h22, 2'b01, 1, 32'h0, 0, 32'hFFFFCAFE, 1);
        do_req(1, 0, 32'h20, 2'b11, 0, 32'h0, 1, 32'h0, 1);

        // Reset while a store sits in WAIT
        check("pre_rst_ready3", 32'(ready[1]), 32'd1);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20;
        size[1] = 2'b10; wdata[1] = 32'h12345678;
        @(negedge clk);
        req[1] = 1'b0;
        check("in_wait_ready3", 32'(ready[1]), 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_ready3", 32'(ready[1]),      32'd0);
        check("mid_rst_resp3",  32'(resp_valid[1]), 32'd0);
        check("mid_rst_rdata3", rdata[1],           32'd0);
        check("mid_rst_fault3", 32'(fault[1]),      32'd0);
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("post_rst_ready3", 32'(ready[1]), 32'd1);
        repeat (6) @(negedge clk);
        do_req(1, 0, 32'h20, 2'b10, 0, 32'h0, 0, 32'hCAFEF00D, 0);

        repeat (5) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q3_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
